// File: rtl/cosim_send_arbiter.sv
// Round-robin arbiter that shares one cosim endpoint send channel among NUM_CLIENTS producers.
// Optional macro COSIM_ARB_SRC_TAG_EN adds DataInSrc, the index of the client whose message is on DataIn.
module cosim_send_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int MSG_BITS    = 192
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CLIENTS-1:0]          ReqValid,
    output logic [NUM_CLIENTS-1:0]          ReqReady,
    input  logic [NUM_CLIENTS*MSG_BITS-1:0] ReqData,
    output logic                            DataInValid,
    input  logic                            DataInReady,
    output logic [MSG_BITS-1:0]             DataIn
`ifdef COSIM_ARB_SRC_TAG_EN
    ,
    output logic [$clog2(NUM_CLIENTS)-1:0]  DataInSrc
`endif
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);

    logic                r_out_full;
    logic [MSG_BITS-1:0] r_out_data;
    logic [IDX_W-1:0]    r_last_grant;

    logic                w_found;
    logic [IDX_W-1:0]    w_winner;
    logic                w_load_ok;
    logic                w_load;
    logic [MSG_BITS-1:0] w_sel_data;

    // Search starts one past the last grant; the wrap is explicit so that a
    // non-power-of-two client count never produces an out-of-range index.
    always_comb begin
        logic [IDX_W:0]   w_sum;
        logic [IDX_W-1:0] w_idx;
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            w_sum = {1'b0, r_last_grant} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_CLIENTS))
                w_sum = w_sum - (IDX_W+1)'(NUM_CLIENTS);
            w_idx = w_sum[IDX_W-1:0];
            if (!w_found && ReqValid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_load_ok  = !r_out_full || DataInReady;
    assign w_load     = w_load_ok && w_found && !rst;
    assign w_sel_data = ReqData[int'(w_winner)*MSG_BITS +: MSG_BITS];

    always_comb begin
        ReqReady = '0;
        if (w_load)
            ReqReady[w_winner] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_full   <= 1'b0;
            r_out_data   <= '0;
            r_last_grant <= IDX_W'(NUM_CLIENTS-1);
        end else if (w_load) begin
            r_out_full   <= 1'b1;
            r_out_data   <= w_sel_data;
            r_last_grant <= w_winner;
        end else if (DataInReady && r_out_full) begin
            r_out_full <= 1'b0;
        end
    end

`ifdef COSIM_ARB_SRC_TAG_EN
    logic [IDX_W-1:0] r_out_src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_out_src <= '0;
        else if (w_load)
            r_out_src <= w_winner;
    end

    assign DataInSrc = r_out_src;
`endif

    assign DataInValid = r_out_full;
    assign DataIn      = r_out_data;

endmodule

// File: tb/tb_cosim_send_arbiter.sv
// Directed bench for cosim_send_arbiter with NUM_CLIENTS=4, MSG_BITS=192.
// With COSIM_ARB_SRC_TAG_EN defined it also checks DataInSrc alignment.
module tb_cosim_send_arbiter;

    localparam int N  = 4;
    localparam int MB = 192;

    logic              clk;
    logic              rst;
    logic [N-1:0]      ReqValid;
    logic [N-1:0]      ReqReady;
    logic [N*MB-1:0]   ReqData;
    logic              DataInValid;
    logic              DataInReady;
    logic [MB-1:0]     DataIn;
`ifdef COSIM_ARB_SRC_TAG_EN
    logic [1:0]        DataInSrc;
`endif

    int checks   = 0;
    int failures = 0;

    cosim_send_arbiter #(.NUM_CLIENTS(N), .MSG_BITS(MB)) dut (
        .clk         (clk),
        .rst         (rst),
        .ReqValid    (ReqValid),
        .ReqReady    (ReqReady),
        .ReqData     (ReqData),
        .DataInValid (DataInValid),
        .DataInReady (DataInReady),
        .DataIn      (DataIn)
`ifdef COSIM_ARB_SRC_TAG_EN
        ,
        .DataInSrc   (DataInSrc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [MB-1:0] got, input logic [MB-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [MB-1:0] msg(input int i);
        msg = {64'(i), 64'hDEAD_0000_0000_0000 | 64'(i), 64'h00AA + 64'(i)};
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        onehot = N'(1 << g);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    initial begin
        int order[6] = '{0, 1, 2, 3, 0, 1};

        rst         = 1'b1;
        ReqValid    = '1;
        DataInReady = 1'b1;
        for (int i = 0; i < N; i++) ReqData[i*MB +: MB] = msg(i);
        #3;
        check_val("reset_valid", MB'(DataInValid), MB'(1'b0));
        check_val("reset_data",  DataIn, '0);
        check_val("reset_ready", MB'(ReqReady), MB'(4'b0000));
        ReqValid = '0;
        tick();
        rst = 1'b0;

        // Single client: same-cycle grant, one-cycle latency, then empty
        ReqValid = 4'b0001;
        #1 check_val("single_grant", MB'(ReqReady), MB'(4'b0001));
        tick();
        ReqValid = 4'b0000;
        check_val("single_valid", MB'(DataInValid), MB'(1'b1));
        check_val("single_data",  DataIn, msg(0));
        tick();
        check_val("single_drain", MB'(DataInValid), MB'(1'b0));

        // Full contention from reset: 0,1,2,3,0,1 with no bubbles
        pulse_reset();
        ReqValid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            #1 check_val($sformatf("rr_grant%0d", c), MB'(ReqReady), MB'(onehot(order[c])));
            tick();
            check_val($sformatf("rr_valid%0d", c), MB'(DataInValid), MB'(1'b1));
            check_val($sformatf("rr_data%0d", c), DataIn, msg(order[c]));
        end

        // Backpressure: output holds client 1, nothing moves for 5 cycles
        DataInReady = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1 check_val($sformatf("bp_ready%0d", c), MB'(ReqReady), MB'(4'b0000));
            check_val($sformatf("bp_data%0d", c), DataIn, msg(1));
            check_val($sformatf("bp_valid%0d", c), MB'(DataInValid), MB'(1'b1));
            tick();
        end
        DataInReady = 1'b1;
        #1 check_val("bp_release_grant", MB'(ReqReady), MB'(onehot(2)));
        tick();
        check_val("bp_release_data", DataIn, msg(2));
        ReqValid = 4'b0000;
        tick();
        check_val("bp_empty", MB'(DataInValid), MB'(1'b0));

        // Sparse: steer last_grant to 1, then clients 1 and 3 alternate
        ReqValid = 4'b0010;
        #1 check_val("sp_setup", MB'(ReqReady), MB'(4'b0010));
        tick();
        ReqValid = 4'b1010;
        #1 check_val("sp_grant3a", MB'(ReqReady), MB'(4'b1000));
        tick();
        check_val("sp_data3a", DataIn, msg(3));
        #1 check_val("sp_grant1", MB'(ReqReady), MB'(4'b0010));
        tick();
        check_val("sp_data1", DataIn, msg(1));
        #1 check_val("sp_grant3b", MB'(ReqReady), MB'(4'b1000));
        tick();
        check_val("sp_data3b", DataIn, msg(3));

        // Asynchronous reset while the output register is full
        check_val("mid_valid_pre", MB'(DataInValid), MB'(1'b1));
        #2 rst = 1'b1;
        #1 check_val("mid_valid_async", MB'(DataInValid), MB'(1'b0));
        check_val("mid_data_async", DataIn, '0);
        check_val("mid_ready_async", MB'(ReqReady), MB'(4'b0000));
        #2 rst = 1'b0;
        ReqValid = 4'b1111;
        #1 check_val("mid_first_grant", MB'(ReqReady), MB'(4'b0001));
        tick();
        check_val("mid_first_data", DataIn, msg(0));

`ifdef COSIM_ARB_SRC_TAG_EN
        ReqValid = 4'b0000;
        pulse_reset();
        check_val("src_reset", MB'(DataInSrc), MB'(2'd0));
        ReqValid = 4'b0101;
        tick();
        check_val("src_first_data", DataIn, msg(0));
        check_val("src_first_tag", MB'(DataInSrc), MB'(2'd0));
        ReqValid = 4'b0100;
        tick();
        check_val("src_second_data", DataIn, msg(2));
        check_val("src_second_tag", MB'(DataInSrc), MB'(2'd2));
`endif

        ReqValid = 4'b0000;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
